spi_mem_ctrl: RTL and testbench
===============================

# spi_mem_ctrl

Memory-port controller between the SPI slave and an 8-bit single-port synchronous RAM. It decodes the 10-bit command words the slave delivers, latches write and read addresses, and issues RAM accesses. Read data returns to the slave as `tx_data`/`tx_valid`. A local host requester shares the RAM port with the SPI path through a two-way round-robin arbiter.

## Interface
- `ADDR_W`, 8: RAM address width; must be ≤ 8, since addresses come from `rx_data[7:0]`.
- `TX_HOLD`, 8: cycles `tx_valid` and `tx_data` are held for the slave to shift out.
- `AUTO_INC`, 1: 1 = post-increment the write/read address after each data access.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `rx_data` in 10: command word from the slave; [9:8] opcode, [7:0] payload.
- `rx_valid` in 1: level from the slave, may stay high several cycles per word.
- `tx_data` out 8: read data to the slave.
- `tx_valid` out 1: read data valid.
- `spi_err` out 1: one-cycle pulse on a rejected SPI command.
- `mem_en` out 1: RAM access strobe.
- `mem_we` out 1: 1 = write.
- `mem_addr` out ADDR_W: RAM address.
- `mem_wdata` out 8: RAM write data.
- `mem_rdata` in 8: RAM read data, valid the cycle after `mem_en & ~mem_we`.
- `host_req` in 1: host request; held until granted.
- `host_we` in 1: host write/read select.
- `host_addr` in ADDR_W: host address.
- `host_wdata` in 8: host write data.
- `host_gnt` out 1: one-cycle pulse, coincident with `mem_en` for the host access.
- `host_rvalid` out 1: one-cycle pulse, the cycle after a host read grant.
- `host_rdata` out 8: equals `mem_rdata` while `host_rvalid` is high.

## Operation
- Command acceptance: accept on the rising edge of `rx_valid`, i.e. `rx_valid=1` in the current cycle and 0 in the previous one. Exactly one accept per word, regardless of how long `rx_valid` stays high.
- Opcode 00 (WADDR): `waddr <= rx_data[ADDR_W-1:0]`, `waddr_ok <= 1`. No RAM access.
- Opcode 01 (WDATA): if `waddr_ok`, post a pending write of `waddr`/`rx_data[7:0]`; otherwise reject.
- Opcode 10 (RADDR): `raddr <= payload`, `raddr_ok <= 1`. No RAM access.
- Opcode 11 (RDATA): if `raddr_ok`, post a pending read of `raddr`; otherwise reject. The payload is ignored.
- Auto-increment: with `AUTO_INC=1`, the relevant address increments when the pending op is issued. It wraps modulo 2^ADDR_W (all-ones → 0). The `*_ok` flags persist.
- Rejection: WDATA/RDATA without the matching `*_ok`, or any data command arriving while an SPI op is still pending. A rejected command is dropped and `spi_err` pulses for one cycle.
- Arbiter: candidates are the SPI pending op and `host_req`. `host_req` is masked in any cycle where `host_gnt=1`. With one candidate, it wins. With both, the one not granted last wins; the last-grant pointer resets to host, so SPI wins the first tie.
- RAM outputs: registered, at most one access per cycle, reads pipelined back-to-back.
- Read return: SPI read data is registered into `tx_data`. `tx_valid` then stays high for `TX_HOLD` cycles, down-counted. A new SPI read return during a hold reloads `tx_data` and restarts the count.
- Host accesses never affect `tx_*`.

## Timing
- Reset values: all outputs 0; `waddr`, `raddr`, `*_ok`, pending, hold counter, `rx_valid` history all 0; pointer = host. Reset is asynchronous, so it takes effect mid-hold or mid-access without waiting for a clock edge.
- SPI path, with C = the cycle in which the `rx_valid` rise is seen:
  - C+1: pending op set (pending requires a valid data command).
  - C+2: `mem_en` high, if the SPI op wins.
  - C+3: `mem_rdata` valid.
  - C+4 … C+3+TX_HOLD: `tx_valid` high.
- Each cycle lost in arbitration delays all of these by one.
- `spi_err` is high in C+1.
- Host path: `host_req` seen in cycle H and winning → `host_gnt` and `mem_en` high in H+1, `host_rvalid` high in H+2 (reads only).
- Host handshake: the host may drop or change `host_req` in the cycle after `host_gnt`.
- Simultaneous events: an accept and an issue in the same cycle are legal. The issue clears the old pending op, and the new op is set pending next cycle with no reject. An address increment on issue and a WADDR/RADDR load in the same cycle: the load wins.

## Structure
- Package `spi_mem_pkg`: opcode constants `CMD_WADDR=2'b00`, `CMD_WDATA=2'b01`, `CMD_RADDR=2'b10`, `CMD_RDATA=2'b11`.
- Submodule `spi_mem_arb2`: two-requester round-robin arbiter with mask input and last-grant pointer.
- Everything else (decode, pending register, RAM output registers, hold counter) lives in `spi_mem_ctrl`.

## Test plan
- Reset mid-hold: assert `rst_n=0` while `tx_valid=1` → `tx_valid`, `mem_en`, `host_gnt` go 0 immediately. After release, RDATA yields `spi_err` because `raddr_ok` is cleared.
- Write/read round trip: send 0x010, then 0x1C3 → `mem_en`/`mem_we`=1, addr 0x10, wdata 0xC3 at C+2. Then send 0x210, 0x300 → read of 0x10, `tx_data=0xC3`, `tx_valid` high exactly 8 cycles from C+4.
- Wrap: WADDR 0xFF, then WDATA 0x11 and WDATA 0x22 → writes to 0xFF then 0x00.
- Level-held `rx_valid`: hold `rx_valid` high 6 cycles with `rx_data=0x1AA` after a WADDR → exactly one RAM write.
- Contention: host write 0x20/0x5A held while an SPI write is pending, pointer = host → SPI granted first, `host_gnt` the next cycle. Repeat the tie → host wins.
- Protocol error: WDATA 0x155 after reset with no WADDR → no `mem_en`, `spi_err` high for one cycle at C+1.

Source files
------------

// File: rtl/spi_mem_pkg.sv
// -----------------------------------------------------------------------------
// spi_mem_pkg
//   Shared definitions for the SPI memory-port controller: the 2-bit opcode
//   carried in rx_data[9:8] of every command word, and a small decode helper.
//   No ports (package).
// -----------------------------------------------------------------------------
package spi_mem_pkg;

    // Opcodes in rx_data[9:8]
    localparam logic [1:0] CMD_WADDR = 2'b00;
    localparam logic [1:0] CMD_WDATA = 2'b01;
    localparam logic [1:0] CMD_RADDR = 2'b10;
    localparam logic [1:0] CMD_RDATA = 2'b11;

    // Data commands are the ones that turn into a RAM access
    function automatic logic is_data_cmd(input logic [1:0] op);
        return (op == CMD_WDATA) || (op == CMD_RDATA);
    endfunction

endpackage : spi_mem_pkg

// File: rtl/spi_mem_arb2.sv
// -----------------------------------------------------------------------------
// spi_mem_arb2
//   Two-requester round-robin arbiter for the shared RAM port.
//   Requester 0 is the SPI pending op, requester 1 is the local host.
//   The host request can be masked (used while the previous host grant is
//   still visible, since the host holds its request through that cycle).
//   On a tie the requester that was not granted last wins; the last-grant
//   pointer resets to "host", so SPI wins the first tie.
//
// Ports
//   clk, rst_n   : clock, asynchronous active-low reset
//   req_spi      : SPI op pending
//   req_host     : host request
//   mask_host    : suppress req_host this cycle
//   gnt_spi      : combinational grant to SPI
//   gnt_host     : combinational grant to host
// -----------------------------------------------------------------------------
module spi_mem_arb2 (
    input  logic clk,
    input  logic rst_n,
    input  logic req_spi,
    input  logic req_host,
    input  logic mask_host,
    output logic gnt_spi,
    output logic gnt_host
);

    logic last_spi_r;   // 1 = SPI was granted last, 0 = host was granted last
    logic host_cand_s;

    // Grant selection: single candidate wins, tie goes to the one not granted last
    always_comb begin
        host_cand_s = req_host & ~mask_host;
        gnt_spi     = 1'b0;
        gnt_host    = 1'b0;
        if (req_spi && host_cand_s) begin
            if (last_spi_r) begin
                gnt_host = 1'b1;
            end else begin
                gnt_spi  = 1'b1;
            end
        end else if (req_spi) begin
            gnt_spi = 1'b1;
        end else if (host_cand_s) begin
            gnt_host = 1'b1;
        end else begin
            gnt_spi  = 1'b0;
            gnt_host = 1'b0;
        end
    end

    // Last-grant pointer, only moves when somebody is actually granted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_spi_r <= 1'b0;
        end else if (gnt_spi) begin
            last_spi_r <= 1'b1;
        end else if (gnt_host) begin
            last_spi_r <= 1'b0;
        end else begin
            last_spi_r <= last_spi_r;
        end
    end

endmodule : spi_mem_arb2

// File: rtl/spi_mem_ctrl.sv
// -----------------------------------------------------------------------------
// spi_mem_ctrl
//   Memory-port controller between an SPI slave and an 8-bit single-port
//   synchronous RAM. Decodes 10-bit command words (WADDR/WDATA/RADDR/RDATA),
//   keeps write/read address registers, posts one pending SPI access at a
//   time and shares the RAM port with a local host through a round-robin
//   arbiter. SPI read data is returned on tx_data and held valid for TX_HOLD
//   cycles.
//
// Ports
//   clk, rst_n            : clock, asynchronous active-low reset
//   rx_data[9:0]          : command word, [9:8] opcode, [7:0] payload
//   rx_valid              : command valid level (accepted on its rising edge)
//   tx_data[7:0]          : SPI read data
//   tx_valid              : SPI read data valid (TX_HOLD cycles)
//   spi_err               : one-cycle pulse on a rejected data command
//   mem_en/mem_we         : RAM strobe / write select (registered)
//   mem_addr/mem_wdata    : RAM address / write data (registered)
//   mem_rdata             : RAM read data, valid the cycle after a read strobe
//   host_req/host_we      : host request (held until granted) / write select
//   host_addr/host_wdata  : host address / write data
//   host_gnt              : one-cycle grant, coincident with mem_en
//   host_rvalid           : one-cycle pulse when host read data is on mem_rdata
//   host_rdata            : mem_rdata while host_rvalid is high, else 0
// -----------------------------------------------------------------------------
module spi_mem_ctrl
    import spi_mem_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32'd8,
    parameter int unsigned TX_HOLD  = 32'd8,
    parameter bit          AUTO_INC = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [9:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    output logic              spi_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [7:0]        host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [7:0]        host_rdata
);

    localparam int unsigned     CNT_W     = $clog2(TX_HOLD + 32'd1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(TX_HOLD - 32'd1);

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic              rx_valid_q_r;
    logic [ADDR_W-1:0] waddr_r;
    logic [ADDR_W-1:0] raddr_r;
    logic              waddr_ok_r;
    logic              raddr_ok_r;

    logic              pend_r;
    logic              pend_we_r;
    logic [ADDR_W-1:0] pend_addr_r;
    logic [7:0]        pend_wdata_r;

    logic              spi_err_r;
    logic              mem_en_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [7:0]        mem_wdata_r;
    logic              host_gnt_r;
    logic              host_rd_r;      // host read strobe is on the RAM port
    logic              host_rvalid_r;  // host read data is on mem_rdata
    logic              spi_rd_r;       // SPI read strobe is on the RAM port
    logic              spi_rdv_r;      // SPI read data is on mem_rdata

    logic [7:0]        tx_data_r;
    logic              tx_valid_r;
    logic [CNT_W-1:0]  hold_cnt_r;

    // ---------------------------------------------------------------------
    // Combinational
    // ---------------------------------------------------------------------
    logic              accept_s;
    logic [1:0]        opcode_s;
    logic              data_cmd_s;
    logic              addr_ok_s;
    logic              busy_s;
    logic              reject_s;
    logic              post_s;
    logic              gnt_spi_s;
    logic              gnt_host_s;
    logic [ADDR_W-1:0] waddr_nx_s;
    logic [ADDR_W-1:0] raddr_nx_s;

    assign accept_s = rx_valid & ~rx_valid_q_r;
    assign opcode_s = rx_data[9:8];

    spi_mem_arb2 u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_spi   (pend_r),
        .req_host  (host_req),
        .mask_host (host_gnt_r),
        .gnt_spi   (gnt_spi_s),
        .gnt_host  (gnt_host_s)
    );

    // Command decode: a data command is rejected without its address, or
    // while an older SPI op is still waiting (an op issuing this cycle frees
    // the slot, so a same-cycle accept is fine)
    always_comb begin
        data_cmd_s = is_data_cmd(opcode_s);
        if (opcode_s == CMD_WDATA) begin
            addr_ok_s = waddr_ok_r;
        end else begin
            addr_ok_s = raddr_ok_r;
        end
        busy_s   = pend_r & ~gnt_spi_s;
        reject_s = accept_s & data_cmd_s & (~addr_ok_s | busy_s);
        post_s   = accept_s & data_cmd_s & ~reject_s;
    end

    // Post-increment on issue; these are also the addresses a same-cycle
    // accept must latch, so back-to-back data commands see the bumped value
    always_comb begin
        waddr_nx_s = waddr_r;
        raddr_nx_s = raddr_r;
        if (gnt_spi_s && AUTO_INC) begin
            if (pend_we_r) begin
                waddr_nx_s = waddr_r + ADDR_W'(1'b1);
            end else begin
                raddr_nx_s = raddr_r + ADDR_W'(1'b1);
            end
        end else begin
            waddr_nx_s = waddr_r;
            raddr_nx_s = raddr_r;
        end
    end

    // rx_valid history, error pulse and address registers (a load beats an increment)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_valid_q_r <= 1'b0;
            spi_err_r    <= 1'b0;
            waddr_r      <= '0;
            raddr_r      <= '0;
            waddr_ok_r   <= 1'b0;
            raddr_ok_r   <= 1'b0;
        end else begin
            rx_valid_q_r <= rx_valid;
            spi_err_r    <= reject_s;
            waddr_r      <= waddr_nx_s;
            raddr_r      <= raddr_nx_s;
            if (accept_s) begin
                case (opcode_s)
                    CMD_WADDR: begin
                        waddr_r    <= rx_data[ADDR_W-1:0];
                        waddr_ok_r <= 1'b1;
                    end
                    CMD_RADDR: begin
                        raddr_r    <= rx_data[ADDR_W-1:0];
                        raddr_ok_r <= 1'b1;
                    end
                    default: begin
                        waddr_ok_r <= waddr_ok_r;
                        raddr_ok_r <= raddr_ok_r;
                    end
                endcase
            end else begin
                waddr_ok_r <= waddr_ok_r;
                raddr_ok_r <= raddr_ok_r;
            end
        end
    end

    // Single-entry pending SPI op: set by an accepted data command, cleared on issue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_r       <= 1'b0;
            pend_we_r    <= 1'b0;
            pend_addr_r  <= '0;
            pend_wdata_r <= 8'h00;
        end else if (post_s) begin
            pend_r       <= 1'b1;
            pend_we_r    <= (opcode_s == CMD_WDATA);
            pend_addr_r  <= (opcode_s == CMD_WDATA) ? waddr_nx_s : raddr_nx_s;
            pend_wdata_r <= rx_data[7:0];
        end else if (gnt_spi_s) begin
            pend_r       <= 1'b0;
        end else begin
            pend_r       <= pend_r;
        end
    end

    // RAM port registers and read-return tracking pipelines
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_en_r      <= 1'b0;
            mem_we_r      <= 1'b0;
            mem_addr_r    <= '0;
            mem_wdata_r   <= 8'h00;
            host_gnt_r    <= 1'b0;
            host_rd_r     <= 1'b0;
            host_rvalid_r <= 1'b0;
            spi_rd_r      <= 1'b0;
            spi_rdv_r     <= 1'b0;
        end else begin
            mem_en_r      <= gnt_spi_s | gnt_host_s;
            host_gnt_r    <= gnt_host_s;
            host_rd_r     <= gnt_host_s & ~host_we;
            host_rvalid_r <= host_rd_r;
            spi_rd_r      <= gnt_spi_s & ~pend_we_r;
            spi_rdv_r     <= spi_rd_r;
            if (gnt_spi_s) begin
                mem_we_r    <= pend_we_r;
                mem_addr_r  <= pend_addr_r;
                mem_wdata_r <= pend_wdata_r;
            end else if (gnt_host_s) begin
                mem_we_r    <= host_we;
                mem_addr_r  <= host_addr;
                mem_wdata_r <= host_wdata;
            end else begin
                mem_we_r    <= 1'b0;
            end
        end
    end

    // SPI read return: capture data, hold tx_valid for TX_HOLD cycles; a new
    // return during a hold reloads the data and restarts the count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data_r  <= 8'h00;
            tx_valid_r <= 1'b0;
            hold_cnt_r <= '0;
        end else if (spi_rdv_r) begin
            tx_data_r  <= mem_rdata;
            tx_valid_r <= 1'b1;
            hold_cnt_r <= HOLD_LOAD;
        end else if (hold_cnt_r != '0) begin
            hold_cnt_r <= hold_cnt_r - CNT_W'(1'b1);
        end else begin
            tx_valid_r <= 1'b0;
        end
    end

    assign tx_data     = tx_data_r;
    assign tx_valid    = tx_valid_r;
    assign spi_err     = spi_err_r;
    assign mem_en      = mem_en_r;
    assign mem_we      = mem_we_r;
    assign mem_addr    = mem_addr_r;
    assign mem_wdata   = mem_wdata_r;
    assign host_gnt    = host_gnt_r;
    assign host_rvalid = host_rvalid_r;
    // RAM read data is only valid in the return cycle, so it is gated rather than registered
    assign host_rdata  = host_rvalid_r ? mem_rdata : 8'h00;

endmodule : spi_mem_ctrl

// File: tb/tb_spi_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_mem_ctrl
//   Directed bench for spi_mem_ctrl (default parameters: ADDR_W=8,
//   TX_HOLD=8, AUTO_INC=1) with a behavioural synchronous RAM attached.
// -----------------------------------------------------------------------------
module tb_spi_mem_ctrl;

    logic       clk;
    logic       rst_n;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       spi_err;
    logic       mem_en;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       host_req;
    logic       host_we;
    logic [7:0] host_addr;
    logic [7:0] host_wdata;
    logic       host_gnt;
    logic       host_rvalid;
    logic [7:0] host_rdata;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] ram [0:255];

    spi_mem_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .spi_err     (spi_err),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .host_req    (host_req),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_gnt    (host_gnt),
        .host_rvalid (host_rvalid),
        .host_rdata  (host_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port RAM: read data appears the cycle after the strobe
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one word for a single cycle (cycle C); returns in C+1
    task automatic send(input logic [9:0] w);
        rx_data  = w;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    int         wr_cnt;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;

    initial begin
        rst_n      = 1'b0;
        rx_valid   = 1'b0;
        rx_data    = 10'h000;
        host_req   = 1'b0;
        host_we    = 1'b0;
        host_addr  = 8'h00;
        host_wdata = 8'h00;
        mem_rdata  = 8'h00;
        #12;

        // ---- reset state
        check("rst_tx_valid",    8'(tx_valid),    8'h00);
        check("rst_tx_data",     tx_data,         8'h00);
        check("rst_mem_en",      8'(mem_en),      8'h00);
        check("rst_mem_we",      8'(mem_we),      8'h00);
        check("rst_mem_addr",    mem_addr,        8'h00);
        check("rst_spi_err",     8'(spi_err),     8'h00);
        check("rst_host_gnt",    8'(host_gnt),    8'h00);
        check("rst_host_rvalid", 8'(host_rvalid), 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // ---- protocol error: WDATA with no WADDR
        send(10'h155);
        check("perr_err_c1", 8'(spi_err), 8'h01);
        tick();
        check("perr_err_c2", 8'(spi_err), 8'h00);
        check("perr_en_c2",  8'(mem_en),  8'h00);
        tick();
        check("perr_en_c3",  8'(mem_en),  8'h00);

        // ---- write/read round trip
        send(10'h010);
        check("rt_waddr_noerr", 8'(spi_err), 8'h00);
        tick();
        send(10'h1C3);
        tick();
        check("rt_wr_en",    8'(mem_en), 8'h01);
        check("rt_wr_we",    8'(mem_we), 8'h01);
        check("rt_wr_addr",  mem_addr,   8'h10);
        check("rt_wr_data",  mem_wdata,  8'hC3);
        tick();
        send(10'h210);
        tick();
        send(10'h300);
        check("rt_rd_noerr", 8'(spi_err), 8'h00);
        tick();
        check("rt_rd_en",    8'(mem_en), 8'h01);
        check("rt_rd_we",    8'(mem_we), 8'h00);
        check("rt_rd_addr",  mem_addr,   8'h10);
        tick();
        check("rt_txv_c3",   8'(tx_valid), 8'h00);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("rt_txv_hold", 8'(tx_valid), 8'h01);
            check("rt_tx_data",  tx_data,      8'hC3);
        end
        tick();
        check("rt_txv_end",  8'(tx_valid), 8'h00);

        // ---- address wrap
        send(10'h0FF);
        tick();
        send(10'h111);
        tick();
        check("wrap_en0",   8'(mem_en), 8'h01);
        check("wrap_addr0", mem_addr,   8'hFF);
        check("wrap_data0", mem_wdata,  8'h11);
        send(10'h122);
        tick();
        check("wrap_en1",   8'(mem_en), 8'h01);
        check("wrap_addr1", mem_addr,   8'h00);
        check("wrap_data1", mem_wdata,  8'h22);

        // ---- level-held rx_valid: one write only
        send(10'h040);
        tick();
        wr_cnt   = 0;
        wr_addr  = 8'h00;
        wr_data  = 8'h00;
        rx_data  = 10'h1AA;
        rx_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 6) rx_valid = 1'b0;
            tick();
            if (mem_en && mem_we) begin
                wr_cnt++;
                wr_addr = mem_addr;
                wr_data = mem_wdata;
            end
        end
        check("lvl_count", 8'(wr_cnt), 8'h01);
        check("lvl_addr",  wr_addr,    8'h40);
        check("lvl_data",  wr_data,    8'hAA);

        // ---- host read alone
        host_req  = 1'b1;
        host_we   = 1'b0;
        host_addr = 8'h10;
        tick();
        check("hrd_gnt",  8'(host_gnt), 8'h01);
        check("hrd_en",   8'(mem_en),   8'h01);
        check("hrd_we",   8'(mem_we),   8'h00);
        check("hrd_addr", mem_addr,     8'h10);
        host_req = 1'b0;
        tick();
        check("hrd_rvalid", 8'(host_rvalid), 8'h01);
        check("hrd_rdata",  host_rdata,      8'hC3);
        check("hrd_no_tx",  8'(tx_valid),    8'h00);
        tick();
        check("hrd_rvalid_end", 8'(host_rvalid), 8'h00);

        // ---- contention with pointer = host: SPI first, host next cycle
        send(10'h030);
        tick();
        send(10'h177);
        host_req   = 1'b1;
        host_we    = 1'b1;
        host_addr  = 8'h20;
        host_wdata = 8'h5A;
        tick();
        check("c1_spi_en",    8'(mem_en),   8'h01);
        check("c1_spi_addr",  mem_addr,     8'h30);
        check("c1_spi_data",  mem_wdata,    8'h77);
        check("c1_spi_nognt", 8'(host_gnt), 8'h00);
        tick();
        check("c1_host_gnt",  8'(host_gnt), 8'h01);
        check("c1_host_we",   8'(mem_we),   8'h01);
        check("c1_host_addr", mem_addr,     8'h20);
        check("c1_host_data", mem_wdata,    8'h5A);
        host_req = 1'b0;
        tick();
        check("c1_gnt_end",   8'(host_gnt), 8'h00);

        // SPI-only write moves the pointer to SPI
        send(10'h188);
        tick();
        check("c2_pre_addr", mem_addr,  8'h31);
        check("c2_pre_data", mem_wdata, 8'h88);

        // ---- tie with pointer = SPI: host wins, SPI next; accept during SPI issue
        send(10'h199);
        host_req   = 1'b1;
        host_addr  = 8'h21;
        host_wdata = 8'h6B;
        tick();
        check("c2_host_gnt",  8'(host_gnt), 8'h01);
        check("c2_host_addr", mem_addr,     8'h21);
        check("c2_host_data", mem_wdata,    8'h6B);
        host_req = 1'b0;
        rx_data  = 10'h1AB;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        check("c2_sim_noerr", 8'(spi_err),  8'h00);
        check("c2_spi_nognt", 8'(host_gnt), 8'h00);
        check("c2_spi_en",    8'(mem_en),   8'h01);
        check("c2_spi_addr",  mem_addr,     8'h32);
        check("c2_spi_data",  mem_wdata,    8'h99);
        tick();
        check("c2_new_en",    8'(mem_en),   8'h01);
        check("c2_new_addr",  mem_addr,     8'h33);
        check("c2_new_data",  mem_wdata,    8'hAB);

        // ---- reset in the middle of a hold and a host access
        send(10'h210);
        tick();
        send(10'h300);
        tick();
        tick();
        tick();
        check("mr_txv_before", 8'(tx_valid), 8'h01);
        host_req  = 1'b1;
        host_we   = 1'b0;
        host_addr = 8'h20;
        tick();
        check("mr_gnt_before", 8'(host_gnt), 8'h01);
        check("mr_en_before",  8'(mem_en),   8'h01);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_txv_async", 8'(tx_valid), 8'h00);
        check("mr_en_async",  8'(mem_en),   8'h00);
        check("mr_gnt_async", 8'(host_gnt), 8'h00);
        host_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        send(10'h300);
        check("mr_rdata_err", 8'(spi_err), 8'h01);
        tick();
        check("mr_rdata_noen", 8'(mem_en),  8'h00);
        check("mr_err_pulse",  8'(spi_err), 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_spi_mem_ctrl
